// File: rtl/myy_pkg.sv
// myy_pkg: shared definitions for the four-operation microprogram controller.
// Holds the controller state encoding, opcode values and the bit positions of
// the BO control vector y[10:1] (also used by BO-level benches).
package myy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARITH,
        MROT,
        MADD,
        FIX,
        FLAG,
        DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    // y-vector bit positions (vector is indexed 10:1)
    localparam int Y_LD_RA  = 1;   // load RA
    localparam int Y_RB_SEL = 2;   // RB load select (1 = load b, 0 = shift)
    localparam int Y_RB_EN  = 3;   // RB clock enable
    localparam int Y_ADD_A  = 4;   // +A to adder
    localparam int Y_SUB_A  = 5;   // -A to adder
    localparam int Y_RR_SEL = 6;   // RR load select (1 = adder, 0 = rotate left)
    localparam int Y_RR_EN  = 7;   // RR clock enable
    localparam int Y_RR_CLR = 8;   // clear RR
    localparam int Y_RR_SRC = 9;   // adder second input = RR (0 = sext RB)
    localparam int Y_FLAG   = 10;  // latch result flag

endpackage

// File: rtl/myy_four_oper.sv
// myy_four_oper: microprogram control unit driving one four-operation BO
// (ADD, SUB, NEG, MUL in ones' complement).
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high
//   start  - operation request, sampled only in IDLE
//   op     - opcode (00 ADD, 01 SUB, 10 MUL, 11 NEG), latched with start
//   f      - BO flags: [0] multiplier sign, [1] analysed multiplier bit,
//            [2] negative zero in RR
//   y      - BO control vector [10:1], acted on by BO at the next edge
//   busy   - high in every state except IDLE
//   done   - one-cycle completion pulse
module myy_four_oper
    import myy_pkg::*;
#(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  f,
    output logic [10:1] y,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y       = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                y[Y_LD_RA]  = 1'b1;
                y[Y_RB_SEL] = 1'b1;
                y[Y_RB_EN]  = 1'b1;
                y[Y_RR_CLR] = 1'b1;
                state_d = (op_q == OP_MUL) ? MROT : ARITH;
            end
            ARITH: begin
                y[Y_RR_SEL] = 1'b1;
                y[Y_RR_EN]  = 1'b1;
                case (op_q)
                    OP_ADD: y[Y_ADD_A] = 1'b1;
                    OP_SUB: y[Y_SUB_A] = 1'b1;
                    OP_NEG: begin
                        // RR was cleared in LOAD, so RR + (-A) = -A
                        y[Y_SUB_A]  = 1'b1;
                        y[Y_RR_SRC] = 1'b1;
                    end
                    default: ;
                endcase
                state_d = FIX;
            end
            MROT: begin
                // rotate-left of a ones' complement value doubles it
                y[Y_RR_EN] = 1'b1;
                state_d    = MADD;
            end
            MADD: begin
                y[Y_RB_EN] = 1'b1;
                // Positive multiplier adds A on a 1 bit; negative multiplier
                // adds -A on a 0 bit (complemented magnitude), so no final
                // correction is needed.
                if (f[0] ^ f[1]) begin
                    y[Y_RR_SEL] = 1'b1;
                    y[Y_RR_EN]  = 1'b1;
                    y[Y_RR_SRC] = 1'b1;
                    y[Y_ADD_A]  = ~f[0];
                    y[Y_SUB_A]  = f[0];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = MROT;
                end
            end
            FIX: begin
                // negative zero is normalised to +0
                y[Y_RR_CLR] = f[2];
                state_d     = FLAG;
            end
            FLAG: begin
                y[Y_FLAG] = 1'b1;
                state_d   = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_myy_four_oper.sv
module tb_myy_four_oper;
    import myy_pkg::*;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  f;
    logic [10:1] y;
    logic        busy;
    logic        done;

    logic [N-1:0] a_in, b_in;
    logic [N-1:0] ra, rb;
    logic [W-1:0] rr;
    logic [W-1:0] opa, opb, sum;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb_q[$];
    logic [10:1]  ylog [0:31];
    logic         blog [0:31];
    logic [W-1:0] rr_done;
    int           first_done, ndone;

    always #5 clk = ~clk;

    myy_four_oper #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .f(f),
        .y(y), .busy(busy), .done(done)
    );

    // ---------------- operation block BO model ----------------
    function automatic logic [W-1:0] sext(input logic [N-1:0] v);
        return {{(W-N){v[N-1]}}, v};
    endfunction

    function automatic logic [W-1:0] add1c(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, z};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    always_comb begin
        opa = '0;
        if (y[Y_ADD_A]) opa = sext(ra);
        else if (y[Y_SUB_A]) opa = ~sext(ra);
        opb = y[Y_RR_SRC] ? rr : sext(rb);
        sum = add1c(opa, opb);
    end

    always @(posedge clk) begin
        if (y[Y_LD_RA]) ra <= a_in;
        if (y[Y_RB_EN]) rb <= y[Y_RB_SEL] ? b_in : {rb[N-1], rb[N-3:0], 1'b0};
        if (y[Y_RR_CLR]) rr <= '0;
        else if (y[Y_RR_EN]) rr <= y[Y_RR_SEL] ? sum : {rr[W-2:0], rr[W-1]};
    end

    assign f = {&rr[N:0], rb[N-2], rb[N-1]};

    // ---------------- reference arithmetic ----------------
    function automatic int sval(input logic [N-1:0] v);
        logic [N-1:0] m;
        m = v[N-1] ? ~v : v;
        return v[N-1] ? -int'(m) : int'(m);
    endfunction

    function automatic logic [W-1:0] ref_rr(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        int r;
        logic [W-1:0] m;
        case (o)
            OP_ADD:  r = sval(a) + sval(b);
            OP_SUB:  r = sval(b) - sval(a);
            OP_MUL:  r = sval(a) * sval(b);
            default: r = -sval(a);
        endcase
        m = W'((r < 0) ? -r : r);
        return (r < 0) ? ~m : m;
    endfunction

    function automatic logic [10:1] yb(input int i);
        logic [10:1] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Drives one request (start in cycle 0) and records y/busy per cycle.
    // Called at a negedge; ends at the negedge of cycle ncyc.
    task automatic run(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int ncyc, input logic [31:0] xs, input int rst_cyc);
        op = o; a_in = a; b_in = b; start = 1'b1; rst = 1'b0;
        first_done = -1; ndone = 0; rr_done = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            ylog[c] = y;
            blog[c] = busy;
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    rr_done = rr;
                end
            end
            start = xs[c];
            rst   = (c == rst_cyc);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        total++; if (y !== 10'b0) begin bad++; $display("FAIL reset_y got=%b exp=0", y); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_add;
        logic [W-1:0] exp;
        logic ball;
        sb_q.push_back(ref_rr(OP_ADD, 4'b0011, 4'b0010));
        run(OP_ADD, 4'b0011, 4'b0010, 7, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (first_done !== 5) begin bad++; $display("FAIL add_lat got=%0d exp=5", first_done); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL add_rr got=%b exp=%b", rr_done, exp); end
        total++; if (ylog[1] !== (yb(Y_LD_RA)|yb(Y_RB_SEL)|yb(Y_RB_EN)|yb(Y_RR_CLR)))
            begin bad++; $display("FAIL add_y_load got=%b", ylog[1]); end
        total++; if (ylog[2] !== (yb(Y_ADD_A)|yb(Y_RR_SEL)|yb(Y_RR_EN)))
            begin bad++; $display("FAIL add_y_arith got=%b", ylog[2]); end
        total++; if (ylog[3] !== 10'b0) begin bad++; $display("FAIL add_y_fix got=%b exp=0", ylog[3]); end
        total++; if (ylog[4] !== yb(Y_FLAG)) begin bad++; $display("FAIL add_y_flag got=%b", ylog[4]); end
        ball = 1'b1;
        for (int c = 1; c <= 5; c++) ball &= blog[c];
        total++; if (ball !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", ball); end
        total++; if (blog[6] !== 1'b0) begin bad++; $display("FAIL add_busy_after got=%b exp=0", blog[6]); end
    endtask

    task automatic test_sub_neg;
        logic [W-1:0] exp;
        sb_q.push_back(ref_rr(OP_SUB, 4'b0011, 4'b0101));
        run(OP_SUB, 4'b0011, 4'b0101, 6, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (rr_done !== exp) begin bad++; $display("FAIL sub_rr got=%b exp=%b", rr_done, exp); end
        total++; if (ylog[2] !== (yb(Y_SUB_A)|yb(Y_RR_SEL)|yb(Y_RR_EN)))
            begin bad++; $display("FAIL sub_y_arith got=%b", ylog[2]); end
        sb_q.push_back(ref_rr(OP_NEG, 4'b0011, 4'b0101));
        run(OP_NEG, 4'b0011, 4'b0101, 6, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (rr_done !== exp) begin bad++; $display("FAIL neg_rr got=%b exp=%b", rr_done, exp); end
        total++; if (ylog[2] !== (yb(Y_SUB_A)|yb(Y_RR_SEL)|yb(Y_RR_EN)|yb(Y_RR_SRC)))
            begin bad++; $display("FAIL neg_y_arith got=%b", ylog[2]); end
        total++; if (first_done !== 5) begin bad++; $display("FAIL neg_lat got=%0d exp=5", first_done); end
    endtask

    task automatic test_mul_pos;
        logic [W-1:0] exp;
        int nrot;
        sb_q.push_back(ref_rr(OP_MUL, 4'b0011, 4'b0010));
        run(OP_MUL, 4'b0011, 4'b0010, 11, 32'd0, -1);
        exp = sb_q.pop_front();
        nrot = 0;
        for (int c = 1; c <= 11; c++) if (ylog[c] === yb(Y_RR_EN)) nrot++;
        total++; if (first_done !== 10) begin bad++; $display("FAIL mulp_lat got=%0d exp=10", first_done); end
        total++; if (nrot !== 3) begin bad++; $display("FAIL mulp_nrot got=%0d exp=3", nrot); end
        total++; if (ylog[3] !== yb(Y_RB_EN)) begin bad++; $display("FAIL mulp_madd1 got=%b", ylog[3]); end
        total++; if (ylog[5] !== (yb(Y_RB_EN)|yb(Y_ADD_A)|yb(Y_RR_SEL)|yb(Y_RR_EN)|yb(Y_RR_SRC)))
            begin bad++; $display("FAIL mulp_madd2 got=%b", ylog[5]); end
        total++; if (ylog[7] !== yb(Y_RB_EN)) begin bad++; $display("FAIL mulp_madd3 got=%b", ylog[7]); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL mulp_rr got=%b exp=%b", rr_done, exp); end
    endtask

    task automatic test_mul_neg;
        logic [W-1:0] exp;
        int nsub;
        sb_q.push_back(ref_rr(OP_MUL, 4'b0011, 4'b1101));
        run(OP_MUL, 4'b0011, 4'b1101, 11, 32'd0, -1);
        exp = sb_q.pop_front();
        nsub = 0;
        for (int c = 1; c <= 11; c++) if (ylog[c][Y_SUB_A] === 1'b1) nsub++;
        total++; if (nsub !== 1) begin bad++; $display("FAIL muln_nsub got=%0d exp=1", nsub); end
        total++; if (ylog[5] !== (yb(Y_RB_EN)|yb(Y_SUB_A)|yb(Y_RR_SEL)|yb(Y_RR_EN)|yb(Y_RR_SRC)))
            begin bad++; $display("FAIL muln_madd2 got=%b", ylog[5]); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL muln_rr got=%b exp=%b", rr_done, exp); end
    endtask

    task automatic test_mul_zero;
        logic [W-1:0] exp;
        sb_q.push_back(ref_rr(OP_MUL, 4'b0000, 4'b1101));
        run(OP_MUL, 4'b0000, 4'b1101, 11, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (ylog[8] !== yb(Y_RR_CLR)) begin bad++; $display("FAIL mulz_fix got=%b", ylog[8]); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL mulz_rr got=%b exp=%b", rr_done, exp); end
    endtask

    task automatic test_negzero;
        logic [W-1:0] exp;
        sb_q.push_back(ref_rr(OP_ADD, 4'b0011, 4'b1100));
        run(OP_ADD, 4'b0011, 4'b1100, 6, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (ylog[3] !== yb(Y_RR_CLR)) begin bad++; $display("FAIL nz_fix got=%b", ylog[3]); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL nz_rr got=%b exp=%b", rr_done, exp); end
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] exp;
        logic bany;
        sb_q.push_back(ref_rr(OP_ADD, 4'b0011, 4'b0010));
        run(OP_ADD, 4'b0011, 4'b0010, 10, (32'd1 << 3) | (32'd1 << 5), -1);
        exp = sb_q.pop_front();
        bany = 1'b0;
        for (int c = 6; c <= 10; c++) bany |= blog[c];
        total++; if (ndone !== 1) begin bad++; $display("FAIL ign_ndone got=%0d exp=1", ndone); end
        total++; if (first_done !== 5) begin bad++; $display("FAIL ign_lat got=%0d exp=5", first_done); end
        total++; if (bany !== 1'b0) begin bad++; $display("FAIL ign_busy_after got=%b exp=0", bany); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL ign_rr got=%b exp=%b", rr_done, exp); end
    endtask

    task automatic test_reset_mid;
        run(OP_MUL, 4'b0011, 4'b0010, 12, 32'd0, 6);
        total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_ndone got=%0d exp=0", ndone); end
        total++; if (ylog[7] !== 10'b0) begin bad++; $display("FAIL rmid_y got=%b exp=0", ylog[7]); end
        total++; if (blog[7] !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", blog[7]); end
        total++; if (blog[6] !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b exp=1", blog[6]); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp;
        sb_q.push_back(ref_rr(OP_SUB, 4'b0001, 4'b0110));
        run(OP_SUB, 4'b0001, 4'b0110, 6, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (first_done !== 5) begin bad++; $display("FAIL b2b_lat0 got=%0d exp=5", first_done); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL b2b_rr0 got=%b exp=%b", rr_done, exp); end
        // next start lands in IDLE, one cycle after done
        sb_q.push_back(ref_rr(OP_MUL, 4'b1100, 4'b0011));
        run(OP_MUL, 4'b1100, 4'b0011, 11, 32'd0, -1);
        exp = sb_q.pop_front();
        total++; if (first_done !== 10) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=10", first_done); end
        total++; if (rr_done !== exp) begin bad++; $display("FAIL b2b_rr1 got=%b exp=%b", rr_done, exp); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_empty got=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = OP_ADD; a_in = '0; b_in = '0;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub_neg;
        test_mul_pos;
        test_mul_neg;
        test_mul_zero;
        test_negzero;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
